// File: rtl/loop_register_left.sv
// loop_register_left: multi-step circular rotate register.
// A word is loaded on an accepted start. It is then rotated one bit per
// clock for the programmed number of steps, and a one-cycle done pulse
// flags the result. The rotation is left by default, which undoes the
// team's right-rotate loop register.
// Optional build macro LOOP_RIGHT_SEL_EN: this macro adds a 'dir' input,
// captured with din. When dir=1 the register rotates right instead.
// Reset is synchronous and active-low.
module loop_register_left #(
  parameter int WIDTH  = 6,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  din,
  input  logic [STEP_W-1:0] steps,
`ifdef LOOP_RIGHT_SEL_EN
  input  logic              dir,
`endif
  output logic [WIDTH-1:0]  dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] cnt;
  logic [WIDTH-1:0]  rot_word;

`ifdef LOOP_RIGHT_SEL_EN
  logic dir_q;

  // Next working word: rotate in the direction captured at start.
  always_comb begin
    if (dir_q) rot_word = {dout[0], dout[WIDTH-1:1]};
    else       rot_word = {dout[WIDTH-2:0], dout[WIDTH-1]};
  end

  // Capture the direction together with the data word.
  always_ff @(posedge clk) begin
    if (!rst_n)                       dir_q <= 1'b0;
    else if (state == IDLE && start)  dir_q <= dir;
  end
`else
  // Next working word: one-bit circular left rotate.
  always_comb begin
    rot_word = {dout[WIDTH-2:0], dout[WIDTH-1]};
  end
`endif

  // State register; the reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // sees pre-edge values regardless of block order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. A start is honoured only in IDLE; a zero step count
  // goes straight to DONE.
  always_comb begin
    // NOTE: the default assigned first keeps every path driven, so no latch.
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (steps != '0) ? ROT : DONE;
      ROT:  if (cnt == STEP_W'(1)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, then rotate and count down once per ROT cycle.
  // cnt is at least 1 in ROT, so the decrement never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dout <= din;
          cnt  <= steps;
        end
        ROT: begin
          dout <= rot_word;
          cnt  <= cnt - STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered flags, decoded from the state being entered.
  // busy matches state != IDLE, and done matches state == DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_loop_register_left.sv
// Testbench for loop_register_left (WIDTH=6, STEP_W=4, 20 ns clock).
// Table-driven single operations plus hand-written reset/busy sequences.
module tb_loop_register_left;

  localparam int WIDTH  = 6;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [WIDTH-1:0]  din;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  dout;
  logic              busy;
  logic              done;
`ifdef LOOP_RIGHT_SEL_EN
  logic              dir;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  loop_register_left #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .steps (steps),
`ifdef LOOP_RIGHT_SEL_EN
    .dir   (dir),
`endif
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]  din;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  exp_dout;
    int                exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock and then wait 1 ns. The DUT outputs are sampled there,
  // and new inputs are applied there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // This task issues one request and waits for done, within a fixed bound.
  // It checks the latency, the result and the flags, and then checks the
  // return to IDLE.
  task automatic run_op(input string name, input logic [WIDTH-1:0] d,
                        input logic [STEP_W-1:0] s, input logic [WIDTH-1:0] exp_d,
                        input int exp_lat);
    int lat;
    din   = d;
    steps = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = '0;
    steps = '0;
    lat   = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " dout"}, dout, exp_d);
    check({name, " busy@done"}, busy, 1'b1);
    tick();
    check({name, " done 1-cycle"}, done, 1'b0);
    check({name, " busy after"}, busy, 1'b0);
    check({name, " dout hold"}, dout, exp_d);
  endtask

  initial begin
    int lat;
    vecs[0] = '{6'b110110, 4'd1,  6'b101101, 2};
    vecs[1] = '{6'b001010, 4'd3,  6'b010001, 4};
    vecs[2] = '{6'b001010, 4'd0,  6'b001010, 1};
    vecs[3] = '{6'b001010, 4'd6,  6'b001010, 7};
    vecs[4] = '{6'b000001, 4'd5,  6'b100000, 6};
    vecs[5] = '{6'b101100, 4'd15, 6'b100101, 16};
    vecs[6] = '{6'b111111, 4'd2,  6'b111111, 3};
    vecs[7] = '{6'b100000, 4'd4,  6'b001000, 5};

    // Reset: assert it for two edges while start=1; start must not be accepted.
    rst_n = 1'b0;
    start = 1'b1;
    din   = 6'b101010;
    steps = 4'd2;
`ifdef LOOP_RIGHT_SEL_EN
    dir   = 1'b0;
`endif
    tick();
    tick();
    check("reset dout", dout, 6'b000000);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post-reset busy", busy, 1'b0);
    check("post-reset dout", dout, 6'b000000);

    // Table-driven operations.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].steps,
             vecs[i].exp_dout, vecs[i].exp_lat);
    end

    // Walk for steps=3: check dout on every cycle.
    din = 6'b001010; steps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("walk c1 dout", dout, 6'b001010);
    check("walk c1 busy", busy, 1'b1);
    tick(); check("walk c2 dout", dout, 6'b010100);
    tick(); check("walk c3 dout", dout, 6'b101000);
    check("walk c3 done", done, 1'b0);
    tick(); check("walk c4 dout", dout, 6'b010001);
    check("walk c4 done", done, 1'b1);
    tick(); check("walk c5 busy", busy, 1'b0);

    // A start that arrives while busy must be ignored.
    din = 6'b001010; steps = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    din = 6'b111111; steps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check("busy-start latency", lat, 7);
    check("busy-start dout", dout, 6'b001010);
    tick();
    check("busy-start idle", busy, 1'b0);

    // A reset in the middle of a rotation discards the operation.
    din = 6'b001010; steps = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset dout", dout, 6'b000000);
    check("midreset busy", busy, 1'b0);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || busy) lat++;
    end
    check("midreset no done", lat, 0);

`ifdef LOOP_RIGHT_SEL_EN
    dir = 1'b1;
    run_op("dir1", 6'b110110, 4'd1, 6'b011011, 2);
    dir = 1'b0;
    run_op("dir0", 6'b110110, 4'd1, 6'b101101, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
